// File: rtl/cmp_result_accumulator.sv
// Frame accumulator for the 4-bit magnitude comparator: counts lg/eq/ls outcomes over
// a frame, records the first non-equal index, flags malformed results, hands back a summary.
module cmp_result_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic             lg,
  input  logic             eq,
  input  logic             ls,
  output logic             busy,
  output logic             done,
  input  logic             out_ack,
  output logic [CNT_W-1:0] cnt_lg,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_ls,
  output logic [CNT_W-1:0] first_neq,
  output logic             neq_seen,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_frame_len;
  logic [CNT_W-1:0] r_idx;
  logic             w_accept;
  logic             w_sample;
  logic             w_last;
  logic             w_oneHot;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_sample = (r_state == S_RUN) && in_valid;
  assign w_last   = w_sample && (r_idx == (r_frame_len - ONE));
  // Exactly one of three set: odd parity rules out 000/110, the AND term rules out 111.
  assign w_oneHot = (lg ^ eq ^ ls) && !(lg && eq && ls);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (frame_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= (w_next == S_RUN);
      done    <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_len <= '0;
      r_idx       <= '0;
      cnt_lg      <= '0;
      cnt_eq      <= '0;
      cnt_ls      <= '0;
      first_neq   <= '0;
      neq_seen    <= 1'b0;
      err         <= 1'b0;
    end else if (w_accept) begin
      r_frame_len <= frame_len;
      r_idx       <= '0;
      cnt_lg      <= '0;
      cnt_eq      <= '0;
      cnt_ls      <= '0;
      first_neq   <= '0;
      neq_seen    <= 1'b0;
      err         <= 1'b0;
    end else if (w_sample) begin
      r_idx <= r_idx + ONE;
      if (w_oneHot) begin
        if (lg) cnt_lg <= cnt_lg + ONE;
        if (eq) cnt_eq <= cnt_eq + ONE;
        if (ls) cnt_ls <= cnt_ls + ONE;
        if ((lg || ls) && !neq_seen) begin
          first_neq <= r_idx;
          neq_seen  <= 1'b1;
        end
      end else begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmp_result_accumulator.sv
// Directed bench for cmp_result_accumulator: a reference model fills a summary
// scoreboard as samples are driven; summaries are popped and compared when done rises.
module tb_cmp_result_accumulator;

  typedef struct {
    int lg;
    int eq;
    int ls;
    int first;
    int neq;
    int err;
  } summary_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] frame_len = '0;
  logic       in_valid = 1'b0;
  logic       lg = 1'b0;
  logic       eq = 1'b0;
  logic       ls = 1'b0;
  logic       out_ack = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] cnt_lg;
  logic [7:0] cnt_eq;
  logic [7:0] cnt_ls;
  logic [7:0] first_neq;
  logic       neq_seen;
  logic       err;

  int nPass  = 0;
  int nFail  = 0;
  int nTotal = 0;

  summary_t sbQ[$];
  summary_t lastSum;
  int mLen, mIdx, mLg, mEq, mLs, mFirst, mNeq, mErr;

  cmp_result_accumulator #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .lg(lg), .eq(eq), .ls(ls),
    .busy(busy), .done(done), .out_ack(out_ack),
    .cnt_lg(cnt_lg), .cnt_eq(cnt_eq), .cnt_ls(cnt_ls),
    .first_neq(first_neq), .neq_seen(neq_seen), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    nTotal++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_cnt_lg"}, int'(cnt_lg), 0);
    checkOutput({tag, "_cnt_eq"}, int'(cnt_eq), 0);
    checkOutput({tag, "_cnt_ls"}, int'(cnt_ls), 0);
    checkOutput({tag, "_first_neq"}, int'(first_neq), 0);
    checkOutput({tag, "_neq_seen"}, int'(neq_seen), 0);
    checkOutput({tag, "_err"}, int'(err), 0);
  endtask

  task automatic pushModel();
    summary_t s;
    s.lg = mLg; s.eq = mEq; s.ls = mLs;
    s.first = mFirst; s.neq = mNeq; s.err = mErr;
    sbQ.push_back(s);
  endtask

  task automatic startFrame(input int len);
    mLen = len; mIdx = 0; mLg = 0; mEq = 0; mLs = 0;
    mFirst = 0; mNeq = 0; mErr = 0;
    @(negedge clk);
    start = 1'b1;
    frame_len = 8'(len);
    @(negedge clk);
    start = 1'b0;
    if (len == 0) pushModel();
  endtask

  task automatic applyStimulus(input logic vLg, input logic vEq, input logic vLs);
    @(negedge clk);
    in_valid = 1'b1;
    lg = vLg; eq = vEq; ls = vLs;
    if (int'(vLg) + int'(vEq) + int'(vLs) == 1) begin
      if (vLg) mLg++;
      if (vEq) mEq++;
      if (vLs) mLs++;
      if ((vLg || vLs) && mNeq == 0) begin
        mFirst = mIdx;
        mNeq   = 1;
      end
    end else begin
      mErr = 1;
    end
    mIdx++;
    if (mIdx == mLen) pushModel();
    @(negedge clk);
    in_valid = 1'b0;
    lg = 1'b0; eq = 1'b0; ls = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for done, then pops the oldest expected summary and compares it.
  task automatic checkSummary(input string tag);
    summary_t s;
    int waited = 0;
    while (done !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_done_wait"}, waited, 0);
    checkOutput({tag, "_sb_nonempty"}, int'(sbQ.size() > 0), 1);
    if (sbQ.size() > 0) begin
      s = sbQ.pop_front();
      lastSum = s;
      checkOutput({tag, "_busy"}, int'(busy), 0);
      checkOutput({tag, "_cnt_lg"}, int'(cnt_lg), s.lg);
      checkOutput({tag, "_cnt_eq"}, int'(cnt_eq), s.eq);
      checkOutput({tag, "_cnt_ls"}, int'(cnt_ls), s.ls);
      checkOutput({tag, "_neq_seen"}, int'(neq_seen), s.neq);
      if (s.neq == 1) checkOutput({tag, "_first_neq"}, int'(first_neq), s.first);
      checkOutput({tag, "_err"}, int'(err), s.err);
    end
  endtask

  task automatic ackFrame(input string tag);
    @(negedge clk);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    checkOutput({tag, "_ack_done"}, int'(done), 0);
    checkOutput({tag, "_ack_busy"}, int'(busy), 0);
    checkOutput({tag, "_ack_retain_eq"}, int'(cnt_eq), lastSum.eq);
  endtask

  initial begin
    // Power-on reset
    idleCycles(2);
    checkAllZero("por");
    rst = 1'b0;
    idleCycles(1);

    // Abort a frame with reset after two samples
    startFrame(4);
    checkOutput("run_busy", int'(busy), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checkAllZero("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    idleCycles(1);

    // Frame of 4 with gapped in_valid: eq, eq, lg, ls
    startFrame(4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("f4_pre_done", int'(done), 0);
    checkOutput("f4_pre_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("f4_latency", int'(done), 1);
    checkSummary("f4");
    checkOutput("f4_first_exact", int'(first_neq), 2);
    ackFrame("f4");

    // Frame of 3 with a malformed middle sample
    startFrame(3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("f3_latency", int'(done), 1);
    checkSummary("f3");

    // Hold in DONE while start and in_valid toggle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = ~start;
      in_valid = ~in_valid;
      lg = 1'b1;
      checkOutput("hold_done", int'(done), 1);
      checkOutput("hold_busy", int'(busy), 0);
      checkOutput("hold_cnt_eq", int'(cnt_eq), lastSum.eq);
      checkOutput("hold_err", int'(err), lastSum.err);
    end
    @(negedge clk);
    in_valid = 1'b0;
    lg = 1'b0;
    out_ack = 1'b1;
    start = 1'b1;
    frame_len = 8'd7;
    @(negedge clk);
    out_ack = 1'b0;
    start = 1'b0;
    checkOutput("ackstart_done", int'(done), 0);
    checkOutput("ackstart_busy", int'(busy), 0);
    @(negedge clk);
    checkOutput("ackstart_busy2", int'(busy), 0);
    checkOutput("ackstart_done2", int'(done), 0);
    checkOutput("ackstart_retain_ls", int'(cnt_ls), lastSum.ls);

    // Empty frame: done the cycle after start
    startFrame(0);
    checkOutput("f0_latency", int'(done), 1);
    checkSummary("f0");
    ackFrame("f0");

    // Maximum frame, all ls
    startFrame(255);
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      ls = 1'b1;
      mLs++;
      if (mNeq == 0) begin
        mFirst = mIdx;
        mNeq = 1;
      end
      mIdx++;
    end
    pushModel();
    @(negedge clk);
    in_valid = 1'b0;
    ls = 1'b0;
    checkOutput("f255_latency", int'(done), 1);
    checkSummary("f255");
    checkOutput("f255_first_exact", int'(first_neq), 0);
    ackFrame("f255");

    checkOutput("sb_drained", sbQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/cmp_result_accumulator.md
Name: cmp_result_accumulator

Overview:
- Downstream consumer of the 4-bit magnitude comparator.
- Samples its one-hot lg/eq/ls result over a frame of N qualified comparisons and keeps per-outcome counts, the index of the first non-equal result, and a sticky malformed-result flag.
- Returns a frame summary to the controller through a done/ack handshake.
- Sits between the comparator and the test/control sequencer.

Parameters:
- CNT_W, 8, width of the frame length, the sample index and every counter. Maximum frame is 2^CNT_W-1 samples.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a frame; honoured only in IDLE
- frame_len  input  CNT_W  number of samples in the frame; latched when start is accepted
- in_valid  input  1  lg/eq/ls are valid this cycle
- lg  input  1  comparator result: a > b
- eq  input  1  comparator result: a == b
- ls  input  1  comparator result: a < b
- busy  output  1  high in RUN
- done  output  1  high in DONE; frame summary is valid
- out_ack  input  1  consumer accepts the summary; honoured only in DONE
- cnt_lg  output  CNT_W  number of lg samples in the frame
- cnt_eq  output  CNT_W  number of eq samples in the frame
- cnt_ls  output  CNT_W  number of ls samples in the frame
- first_neq  output  CNT_W  index (0-based) of the first lg or ls sample; valid only when neq_seen=1
- neq_seen  output  1  at least one non-equal sample occurred in the frame
- err  output  1  sticky: a malformed result (not exactly one-hot) occurred in the frame

Behaviour:
- All outputs are registered. On rst (async, any state) every output and internal register goes to 0 and the state goes to IDLE.
- IDLE:
  - busy=0, done=0.
  - start=1 latches frame_len and clears the counts, first_neq, neq_seen, err and the sample index.
  - Next state is RUN, or DONE directly if frame_len=0.
  - in_valid is ignored in IDLE.
- RUN:
  - busy=1.
  - Each cycle with in_valid=1 consumes exactly one sample and increments the index.
  - {lg,eq,ls} exactly one-hot: increment the matching counter. If lg or ls and neq_seen=0, set first_neq to the current index and set neq_seen.
  - Not one-hot (000, 110, 111, ...): set err; no counter changes; the sample still consumes an index.
  - When the sample at index frame_len-1 is consumed, go to DONE on the next edge. That last sample's counts are visible in the same cycle done rises.
  - start in RUN is ignored.
- DONE:
  - done=1, busy=0; summary outputs are held stable.
  - out_ack=1 returns to IDLE with done=0 next cycle. The summary values are retained until the next accepted start.
  - start in DONE is ignored, including a start in the same cycle as out_ack; a new frame needs start while in IDLE.
  - in_valid is ignored.
- Latency: done asserts one cycle after the final sample's in_valid cycle.
- Invariant at DONE: cnt_lg+cnt_eq+cnt_ls+(malformed count) = frame_len. Counters never overflow, since each is ≤ frame_len.
- Reset during RUN or DONE aborts the frame; no partial done is ever produced.

Test Plan:
- Reset mid-RUN after 2 samples: all outputs 0, state IDLE; the next start begins a fresh frame with zeroed counts.
- start, frame_len=4, samples eq,eq,lg,ls (in_valid gapped with idle cycles):
  - done asserts one cycle after the 4th sample.
  - cnt_eq=2, cnt_lg=1, cnt_ls=1, first_neq=2, neq_seen=1, err=0.
- frame_len=3, samples eq, {lg,eq}=11, ls:
  - cnt_eq=1, cnt_ls=1, cnt_lg=0, err=1.
  - first_neq=2 (the malformed sample is not counted as non-equal).
- frame_len=0: done asserts the cycle after start; all counts 0, neq_seen=0.
- In DONE, hold out_ack=0 for 5 cycles with start and in_valid toggling: outputs stable, no new frame. Then out_ack=1 together with start=1: returns to IDLE, start ignored, busy stays 0.
- frame_len=255 (CNT_W=8), all samples ls: cnt_ls=255, first_neq=0, no wrap.
